// File: rtl/harris_padder_pkg.sv
// harris_padder_pkg: shared pixel type and padder FSM states
package harris_padder_pkg;
  localparam int PIX_W = 16;
  typedef logic [PIX_W-1:0] pix_t;
  typedef enum logic [2:0] {S_TOP, S_ROW_LEFT, S_ROW_BODY, S_ROW_RIGHT, S_BOTTOM} pad_state_t;
endpackage

// File: rtl/harris_input_padder_if.sv
// harris_input_padder_if: raw pixel input, padded FWFT read side and status
interface harris_input_padder_if;
  import harris_padder_pkg::*;
  logic flush;
  logic in_valid;
  logic in_ready;
  pix_t in_data;
  logic padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read_en;
  pix_t padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read [0:0];
  logic rd_valid;
  logic frame_done;
  logic underrun;
  modport master (
    input  flush, in_valid, in_data, padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read_en,
    output in_ready, padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read, rd_valid, frame_done, underrun
  );
  modport slave (
    output flush, in_valid, in_data, padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read_en,
    input  in_ready, padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read, rd_valid, frame_done, underrun
  );
endinterface

// File: rtl/harris_padder_fifo.sv
// harris_padder_fifo: synchronous first-word-fall-through skid FIFO with flush
module harris_padder_fifo
  import harris_padder_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  pix_t din,
  output pix_t head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  pix_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign wr = push & !full;
  assign rd = pop & !empty;
  assign head = mem[rp];
  always_ff @(posedge clk) begin
    if (rst | flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/harris_input_padder.sv
// harris_input_padder: zero-pads a raw pixel stream into a FWFT padded raster.
// Define HARRIS_PADDER_STATS_EN to add frames_out/stall_cycles counters.
module harris_input_padder
  import harris_padder_pkg::*;
#(
  parameter int   IMG_W      = 64,
  parameter int   IMG_H      = 64,
  parameter int   PAD        = 1,
  parameter pix_t PAD_VALUE  = '0,
  parameter int   FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  harris_input_padder_if.master bus
`ifdef HARRIS_PADDER_STATS_EN
  ,
  output logic [31:0] frames_out,
  output logic [31:0] stall_cycles
`endif
);
  localparam int PW = IMG_W + 2*PAD;
  localparam int PH = IMG_H + 2*PAD;
  localparam int CW = $clog2((PW > PH ? PW : PH) + 1);
  localparam logic [CW-1:0] TOP_END = CW'(PAD);
  localparam logic [CW-1:0] BOT_START = CW'(PAD + IMG_H);
  localparam logic [CW-1:0] RIGHT_START = CW'(PAD + IMG_W);
  localparam logic [CW-1:0] COL_LAST = CW'(PW - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(PH - 1);
  localparam pad_state_t S_INIT = PAD > 0 ? S_TOP : S_ROW_BODY;
  pad_state_t state, state_nx;
  logic [CW-1:0] row, col, row_nx, col_nx;
  logic body, rd_valid, read_en, pop, push, last_col, last_row, fifo_full, fifo_empty, underrun, frame_done;
  pix_t head;
  // Region is a pure function of position, so zero-width regions are skipped naturally.
  function automatic pad_state_t classify(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return (PAD > 0 && r < TOP_END) ? S_TOP :
           (r >= BOT_START)         ? S_BOTTOM :
           (PAD > 0 && c < TOP_END) ? S_ROW_LEFT :
           (c >= RIGHT_START)       ? S_ROW_RIGHT : S_ROW_BODY;
  endfunction
  always_comb begin
    read_en = bus.padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read_en;
    body = state == S_ROW_BODY;
    rd_valid = !rst_n & (!body | !fifo_empty);
    pop = read_en & rd_valid;
    last_col = col == COL_LAST;
    last_row = row == ROW_LAST;
    col_nx = pop ? (last_col ? '0 : col + 1'b1) : col;
    row_nx = (pop & last_col) ? (last_row ? '0 : row + 1'b1) : row;
    state_nx = classify(row_nx, col_nx);
  end
  always_ff @(posedge clk) begin
    if (rst_n | bus.flush) begin
      state <= S_INIT;
      row <= '0;
      col <= '0;
      underrun <= 1'b0;
    end else begin
      state <= state_nx;
      row <= row_nx;
      col <= col_nx;
      underrun <= underrun | (read_en & !rd_valid);
    end
    frame_done <= !rst_n & !bus.flush & pop & last_row & last_col;
  end
  assign push = bus.in_valid & bus.in_ready;
  harris_padder_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst_n), .flush(bus.flush), .push(push), .pop(pop & body),
    .din(bus.in_data), .head(head), .full(fifo_full), .empty(fifo_empty)
  );
  assign bus.in_ready = !rst_n & !fifo_full;
  assign bus.rd_valid = rd_valid;
  assign bus.frame_done = frame_done;
  assign bus.underrun = underrun;
  assign bus.padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read[0] = body ? head : PAD_VALUE;
`ifdef HARRIS_PADDER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      frames_out <= '0;
      stall_cycles <= '0;
    end else begin
      frames_out <= frames_out + 32'(frame_done && frames_out != '1);
      stall_cycles <= stall_cycles + 32'(read_en && !rd_valid && stall_cycles != '1);
    end
  end
`endif
endmodule

// File: tb/tb_harris_input_padder.sv
// tb_harris_input_padder: directed checks of the padder on a 4x3 image with 1-pixel zero pad
module tb_harris_input_padder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int pass_cnt = 0, fail_cnt = 0, total = 0;
  int pops, next_pix, fd_count, ncyc, done_cyc;
  logic [15:0] rd_word;
`ifdef HARRIS_PADDER_STATS_EN
  logic [31:0] frames_out, stall_cycles;
`endif
  harris_input_padder_if bus ();
  harris_input_padder #(.IMG_W(4), .IMG_H(3), .PAD(1), .PAD_VALUE(16'h0), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef HARRIS_PADDER_STATS_EN
    , .frames_out(frames_out), .stall_cycles(stall_cycles)
`endif
  );
  assign rd_word = bus.padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read[0];
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Padded 6x5 raster; frame f carries pixels 12f+1..12f+12 in its interior.
  function automatic logic [15:0] exp_word(input int idx);
    int f, p, r, c;
    f = idx / 30;
    p = idx % 30;
    r = p / 6;
    c = p % 6;
    return (r == 0 || r == 4 || c == 0 || c == 5) ? 16'h0 : 16'(f*12 + (r-1)*4 + c);
  endfunction
  task automatic reset_dut();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.flush = 1'b0;
    bus.padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_read", rd_word, 0);
    chk("rst_underrun", bus.underrun, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    rst_n = 1'b0;
    pops = 0;
    next_pix = 1;
    fd_count = 0;
    ncyc = 0;
    done_cyc = 0;
  endtask
  task automatic cyc(input logic iv, input logic [15:0] d, input logic re, input logic fl);
    logic pushed, popped;
    ncyc++;
    bus.in_valid = iv;
    bus.in_data = d;
    bus.padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read_en = re;
    bus.flush = fl;
    #1;
    pushed = iv & bus.in_ready & !fl;
    popped = re & bus.rd_valid & !fl;
    if (popped) begin
      chk($sformatf("word%0d", pops), rd_word, exp_word(pops));
      pops++;
    end
    if (pushed) next_pix++;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    if (bus.frame_done) begin
      fd_count++;
      if (done_cyc == 0) done_cyc = ncyc + 1;
    end
  endtask
  initial begin
    // full frame with continuous input and reader
    reset_dut();
    while (fd_count == 0 && ncyc < 100) cyc(next_pix <= 12, 16'(next_pix), 1'b1, 1'b0);
    chk("full_pops", pops, 30);
    chk("full_done_cycle", done_cyc, 31);
    chk("full_inputs", next_pix, 13);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("done_pulse_one_cycle", bus.frame_done, 0);
    chk("wrap_read_pad", rd_word, 0);
    chk("wrap_rd_valid", bus.rd_valid, 1);
    // starvation
    reset_dut();
    repeat (12) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("starve_pops", pops, 7);
    chk("starve_rd_valid", bus.rd_valid, 0);
    chk("starve_underrun", bus.underrun, 1);
`ifdef HARRIS_PADDER_STATS_EN
    chk("stall_cycles", stall_cycles, 5);
`endif
    repeat (2) cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("underrun_sticky", bus.underrun, 1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("flush_clears_underrun", bus.underrun, 0);
`ifdef HARRIS_PADDER_STATS_EN
    chk("stall_after_flush", stall_cycles, 5);
`endif
    // backpressure
    reset_dut();
    repeat (10) cyc(1'b1, 16'(next_pix), 1'b0, 1'b0);
    chk("bp_accepted", next_pix, 9);
    chk("bp_in_ready_low", bus.in_ready, 0);
    chk("bp_no_pop", pops, 0);
    while (fd_count == 0 && ncyc < 200) cyc(next_pix <= 12, 16'(next_pix), 1'b1, 1'b0);
    chk("bp_pops", pops, 30);
    chk("bp_frame_done", fd_count, 1);
    // mid-frame flush
    reset_dut();
    repeat (5) cyc(1'b1, 16'(next_pix), 1'b0, 1'b0);
    repeat (20) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("mf_pops_before_stall", pops, 14);
    chk("mf_underrun", bus.underrun, 1);
    cyc(1'b1, 16'(next_pix), 1'b1, 1'b0);
    cyc(1'b1, 16'(next_pix), 1'b1, 1'b0);
    chk("mf_pops", pops, 15);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    chk("mf_read_origin", rd_word, 0);
    chk("mf_rd_valid", bus.rd_valid, 1);
    chk("mf_underrun_cleared", bus.underrun, 0);
    chk("mf_in_ready", bus.in_ready, 1);
    pops = 0;
    repeat (10) cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("mf_fifo_emptied", pops, 7);
    chk("mf_starved", bus.rd_valid, 0);
    // back-to-back frames
    reset_dut();
    while (fd_count < 2 && ncyc < 300) cyc(next_pix <= 24, 16'(next_pix), 1'b1, 1'b0);
    chk("b2b_frame_done", fd_count, 2);
    chk("b2b_pops", pops, 60);
`ifdef HARRIS_PADDER_STATS_EN
    chk("frames_out", frames_out, 2);
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
